// File: rtl/tag_alloc_scheduler.sv
// -----------------------------------------------------------------------------
// tag_alloc_scheduler
//
// Arbitrates AR requests from NUM_REQ requesters, obtains a unique ID from an
// external tag allocator, and forwards one remapped AR downstream at a time.
// Released unique IDs are queued in a small FIFO and returned to the allocator
// one at a time.
//
// Alloc path : IDLE -> ALLOC -> HOLD -> IDLE (one AR in flight)
// Free path  : FIDLE -> FWAIT -> FIDLE       (one free in flight)
// The two paths run independently of each other.
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous active-low reset
//   req_valid      per-requester AR valid
//   req_id         per-requester original ID, lane i at [i*ID_WIDTH +: ID_WIDTH]
//   req_ready      per-requester accept (winner only, on the grant cycle)
//   alloc_req      request to allocator
//   alloc_orig_id  original ID presented to allocator
//   alloc_gnt      same-cycle allocator grant
//   alloc_uid      unique ID returned with the grant
//   out_valid      remapped AR valid
//   out_uid        remapped ID
//   out_src        winning requester index
//   out_ready      downstream accept
//   rel_valid      release request
//   rel_uid        unique ID to release
//   rel_ready      release FIFO not full
//   free_req       free request to allocator (one cycle per entry)
//   free_uid       unique ID being freed
//   free_ack       allocator free acknowledge, one cycle after free_req
//   done_valid     one-cycle pulse after free_ack is seen
//   done_id        restored original ID, sampled together with free_req
//   stall_cnt      (TAG_SCHED_STALL_CNT_EN only) saturating count of ALLOC
//                  cycles without a grant
//
// Optional feature macro: TAG_SCHED_STALL_CNT_EN
// -----------------------------------------------------------------------------
module tag_alloc_scheduler #(
    parameter int ID_WIDTH   = 4,
    parameter int UID_W      = 4,
    parameter int NUM_REQ    = 2,
    parameter int FREE_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ID_WIDTH-1:0] req_id,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        alloc_req,
    output logic [ID_WIDTH-1:0]         alloc_orig_id,
    input  logic                        alloc_gnt,
    input  logic [UID_W-1:0]            alloc_uid,
    output logic                        out_valid,
    output logic [UID_W-1:0]            out_uid,
    output logic [$clog2(NUM_REQ)-1:0]  out_src,
    input  logic                        out_ready,
    input  logic                        rel_valid,
    input  logic [UID_W-1:0]            rel_uid,
    output logic                        rel_ready,
    output logic                        free_req,
    output logic [UID_W-1:0]            free_uid,
    input  logic                        free_ack,
    output logic                        done_valid,
    input  logic [ID_WIDTH-1:0]         done_id
`ifdef TAG_SCHED_STALL_CNT_EN
    ,
    output logic [15:0]                 stall_cnt
`endif
);

    localparam int SW = $clog2(NUM_REQ);
    localparam int PW = $clog2(FREE_DEPTH) + 1;
    localparam int AW = PW - 1;
    localparam logic [SW-1:0] LAST_INIT = SW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ALLOC = 2'b01,
        HOLD  = 2'b10
    } alloc_state_t;

    typedef enum logic {
        FIDLE = 1'b0,
        FWAIT = 1'b1
    } free_state_t;

    // ---------------------------------------------------------------- alloc
    alloc_state_t          alloc_state_r;
    alloc_state_t          alloc_next_s;
    logic [SW-1:0]         win_r;
    logic [SW-1:0]         last_r;
    logic [ID_WIDTH-1:0]   id_r;
    logic [UID_W-1:0]      uid_r;
    logic [SW-1:0]         win_s;
    logic                  any_s;
    logic [ID_WIDTH-1:0]   sel_id_s;

    // Round-robin search starting one past the last winner, wrapping at NUM_REQ-1.
    always_comb begin
        win_s = last_r;
        any_s = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = int'(last_r) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end else begin
                idx = idx;
            end
            if (!any_s && req_valid[idx]) begin
                any_s = 1'b1;
                win_s = SW'(idx);
            end else begin
                any_s = any_s;
            end
        end
    end

    assign sel_id_s = req_id[win_s*ID_WIDTH +: ID_WIDTH];

    // Alloc FSM next-state.
    always_comb begin
        alloc_next_s = alloc_state_r;
        case (alloc_state_r)
            IDLE: begin
                if (any_s) alloc_next_s = ALLOC;
                else       alloc_next_s = IDLE;
            end
            ALLOC: begin
                if (alloc_gnt) alloc_next_s = HOLD;
                else           alloc_next_s = ALLOC;
            end
            HOLD: begin
                if (out_ready) alloc_next_s = IDLE;
                else           alloc_next_s = HOLD;
            end
            default: alloc_next_s = IDLE;
        endcase
    end

    // Alloc FSM state, winner/ID latch on arbitration, unique ID latch on grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alloc_state_r <= IDLE;
            win_r         <= {SW{1'b0}};
            last_r        <= LAST_INIT;
            id_r          <= {ID_WIDTH{1'b0}};
            uid_r         <= {UID_W{1'b0}};
        end else begin
            alloc_state_r <= alloc_next_s;
            if (alloc_state_r == IDLE && any_s) begin
                win_r  <= win_s;
                last_r <= win_s;
                id_r   <= sel_id_s;
            end
            if (alloc_state_r == ALLOC && alloc_gnt) begin
                uid_r <= alloc_uid;
            end
        end
    end

    // Accept is pulsed only for the latched winner, in the grant cycle.
    always_comb begin
        req_ready = {NUM_REQ{1'b0}};
        if (alloc_state_r == ALLOC && alloc_gnt) begin
            req_ready[win_r] = 1'b1;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
    end

    // Outputs are decoded from state registers and read as zero when inactive.
    assign alloc_req     = (alloc_state_r == ALLOC);
    assign alloc_orig_id = alloc_req ? id_r : {ID_WIDTH{1'b0}};
    assign out_valid     = (alloc_state_r == HOLD);
    assign out_uid       = out_valid ? uid_r : {UID_W{1'b0}};
    assign out_src       = out_valid ? win_r : {SW{1'b0}};

`ifdef TAG_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt_r;

    // Saturating count of ALLOC cycles that did not receive a grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r <= 16'h0000;
        end else if (alloc_state_r == ALLOC && !alloc_gnt && stall_cnt_r != 16'hFFFF) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

    // ---------------------------------------------------------- release FIFO
    logic [UID_W-1:0]    fifo_mem_r [FREE_DEPTH];
    logic [PW-1:0]       wr_ptr_r;
    logic [PW-1:0]       rd_ptr_r;
    logic                fifo_empty_s;
    logic                fifo_full_s;
    logic                push_s;
    logic                pop_s;

    // Extra MSB distinguishes full from empty when the index bits match.
    assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
    assign fifo_full_s  = (wr_ptr_r[PW-1] != rd_ptr_r[PW-1]) &&
                          (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign rel_ready    = !fifo_full_s;
    assign push_s       = rel_valid && !fifo_full_s;

    // FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            for (int i = 0; i < FREE_DEPTH; i++) begin
                fifo_mem_r[i] <= {UID_W{1'b0}};
            end
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r[AW-1:0]] <= rel_uid;
                wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
        end
    end

    // --------------------------------------------------------------- free
    free_state_t         free_state_r;
    free_state_t         free_next_s;
    logic                done_valid_r;
    logic [ID_WIDTH-1:0] done_id_r;

    assign free_req = (free_state_r == FIDLE) && !fifo_empty_s;
    assign pop_s    = free_req;
    assign free_uid = free_req ? fifo_mem_r[rd_ptr_r[AW-1:0]] : {UID_W{1'b0}};

    // Free FSM next-state; acks outside FWAIT have no effect.
    always_comb begin
        free_next_s = free_state_r;
        case (free_state_r)
            FIDLE: begin
                if (free_req) free_next_s = FWAIT;
                else          free_next_s = FIDLE;
            end
            FWAIT: begin
                if (free_ack) free_next_s = FIDLE;
                else          free_next_s = FWAIT;
            end
            default: free_next_s = FIDLE;
        endcase
    end

    // Free FSM state, restored-ID capture and done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            free_state_r <= FIDLE;
            done_valid_r <= 1'b0;
            done_id_r    <= {ID_WIDTH{1'b0}};
        end else begin
            free_state_r <= free_next_s;
            done_valid_r <= (free_state_r == FWAIT) && free_ack;
            if (free_req) begin
                done_id_r <= done_id;
            end
        end
    end

    assign done_valid = done_valid_r;

endmodule

// File: tb/tb_tag_alloc_scheduler.sv
module tb_tag_alloc_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [7:0]  req_id = 8'h00;
    logic [1:0]  req_ready;
    logic        alloc_req;
    logic [3:0]  alloc_orig_id;
    logic        alloc_gnt = 1'b0;
    logic [3:0]  alloc_uid = 4'h0;
    logic        out_valid;
    logic [3:0]  out_uid;
    logic [0:0]  out_src;
    logic        out_ready = 1'b0;
    logic        rel_valid = 1'b0;
    logic [3:0]  rel_uid = 4'h0;
    logic        rel_ready;
    logic        free_req;
    logic [3:0]  free_uid;
    logic        free_ack = 1'b0;
    logic        done_valid;
    logic [3:0]  done_id = 4'h0;
`ifdef TAG_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    tag_alloc_scheduler #(
        .ID_WIDTH(4), .UID_W(4), .NUM_REQ(2), .FREE_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_id(req_id), .req_ready(req_ready),
        .alloc_req(alloc_req), .alloc_orig_id(alloc_orig_id),
        .alloc_gnt(alloc_gnt), .alloc_uid(alloc_uid),
        .out_valid(out_valid), .out_uid(out_uid), .out_src(out_src),
        .out_ready(out_ready),
        .rel_valid(rel_valid), .rel_uid(rel_uid), .rel_ready(rel_ready),
        .free_req(free_req), .free_uid(free_uid), .free_ack(free_ack),
        .done_valid(done_valid), .done_id(done_id)
`ifdef TAG_SCHED_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [1:0] rv;   logic [7:0] rid; logic gnt; logic [3:0] auid;
        logic ordy;       logic relv;      logic [3:0] reluid;
        logic fack;       logic [3:0] did;
        logic [1:0] rr;   logic areq;      logic [3:0] aoid;
        logic ov;         logic [3:0] ouid; logic osrc;
        logic relr;       logic freq;      logic [3:0] fuid; logic dv;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(
        input logic [1:0] rv, input logic [7:0] rid, input logic gnt, input logic [3:0] auid,
        input logic ordy, input logic relv, input logic [3:0] reluid,
        input logic fack, input logic [3:0] did,
        input logic [1:0] rr, input logic areq, input logic [3:0] aoid,
        input logic ov, input logic [3:0] ouid, input logic osrc,
        input logic relr, input logic freq, input logic [3:0] fuid, input logic dv);
        vec_t v;
        v.rv = rv; v.rid = rid; v.gnt = gnt; v.auid = auid; v.ordy = ordy;
        v.relv = relv; v.reluid = reluid; v.fack = fack; v.did = did;
        v.rr = rr; v.areq = areq; v.aoid = aoid; v.ov = ov; v.ouid = ouid;
        v.osrc = osrc; v.relr = relr; v.freq = freq; v.fuid = fuid; v.dv = dv;
        return v;
    endfunction

    initial begin
        logic [3:0] exp_uid [3];
        //             rv     rid    gnt   auid  ordy  relv  reluid fack  did  | rr     areq  aoid  ov    ouid  osrc  relr  freq  fuid  dv
        vecs[0] = mk(2'd0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
        vecs[1] = mk(2'd3, 8'h53, 1'b1, 4'h1, 1'b1, 1'b1, 4'h7, 1'b0, 4'h0, 2'd0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
        vecs[2] = mk(2'd3, 8'h53, 1'b1, 4'h1, 1'b1, 1'b0, 4'h0, 1'b0, 4'hC, 2'd1, 1'b1, 4'h3, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'h7, 1'b0);
        vecs[3] = mk(2'd3, 8'h53, 1'b1, 4'h1, 1'b1, 1'b0, 4'h0, 1'b1, 4'h0, 2'd0, 1'b0, 4'h0, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
        vecs[4] = mk(2'd3, 8'h53, 1'b1, 4'h2, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1);
        vecs[5] = mk(2'd3, 8'h53, 1'b1, 4'h2, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 2'd2, 1'b1, 4'h5, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
        vecs[6] = mk(2'd0, 8'h00, 1'b1, 4'h3, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0, 4'h0, 1'b1, 4'h2, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
        vecs[7] = mk(2'd0, 8'h00, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0, 4'h0, 1'b1, 4'h2, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
        vecs[8] = mk(2'd0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 4'h0, 2'd0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
        vecs[9] = mk(2'd0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);

        // Values while reset is held.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rel_ready", 32'(rel_ready), 32'd1);
        chk("rst_outputs", 32'({req_ready, alloc_req, out_valid, free_req, done_valid}), 32'd0);
        rst = 1'b1;

        // Cycle-by-cycle table: two-requester round robin with a release in parallel.
        for (int i = 0; i < 10; i++) begin
            req_valid = vecs[i].rv;   req_id   = vecs[i].rid;
            alloc_gnt = vecs[i].gnt;  alloc_uid = vecs[i].auid;
            out_ready = vecs[i].ordy; rel_valid = vecs[i].relv;
            rel_uid   = vecs[i].reluid; free_ack = vecs[i].fack;
            done_id   = vecs[i].did;
            #1;
            chk($sformatf("vec%0d", i),
                32'({req_ready, alloc_req, alloc_orig_id, out_valid, out_uid, out_src,
                     rel_ready, free_req, free_uid, done_valid}),
                32'({vecs[i].rr, vecs[i].areq, vecs[i].aoid, vecs[i].ov, vecs[i].ouid,
                     vecs[i].osrc, vecs[i].relr, vecs[i].freq, vecs[i].fuid, vecs[i].dv}));
            @(posedge clk);
            #1;
        end
        free_ack = 1'b0;

        // Grant withheld for 5 cycles; requester drops valid but stays selected.
        req_valid = 2'b01; req_id = 8'h06; alloc_gnt = 1'b0; out_ready = 1'b0;
        tick();
        req_valid = 2'b00;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall_areq%0d", i), 32'({alloc_req, alloc_orig_id, req_ready}), 32'({1'b1, 4'h6, 2'b00}));
            tick();
        end
        alloc_gnt = 1'b1; alloc_uid = 4'hA;
        #1;
        chk("stall_grant", 32'({alloc_req, req_ready}), 32'({1'b1, 2'b01}));
        tick();
        alloc_gnt = 1'b0; alloc_uid = 4'h0;
        chk("stall_hold0", 32'({out_valid, out_uid, out_src, alloc_req}), 32'({1'b1, 4'hA, 1'b0, 1'b0}));
`ifdef TAG_SCHED_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'd5);
`endif
        tick();
        chk("stall_hold1", 32'({out_valid, out_uid, out_src}), 32'({1'b1, 4'hA, 1'b0}));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("stall_done", 32'(out_valid), 32'd0);

        // Release FIFO fill while the free path waits on an ack.
        rel_valid = 1'b1; rel_uid = 4'h1;
        tick();
        rel_valid = 1'b0;
        chk("fifo_first_free", 32'({free_req, free_uid}), 32'({1'b1, 4'h1}));
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fifo_ready%0d", i), 32'(rel_ready), 32'd1);
            rel_valid = 1'b1; rel_uid = 4'(i + 2);
            tick();
        end
        rel_valid = 1'b0;
        chk("fifo_full", 32'({rel_ready, free_req}), 32'({1'b0, 1'b0}));
        rel_valid = 1'b1; rel_uid = 4'hF;
        tick();
        rel_valid = 1'b0;
        free_ack = 1'b1;
        tick();
        free_ack = 1'b0;
        chk("fifo_ack1", 32'({done_valid, free_req, free_uid, rel_ready}), 32'({1'b1, 1'b1, 4'h2, 1'b0}));
        tick();
        chk("fifo_after_pop", 32'({rel_ready, done_valid, free_req}), 32'({1'b1, 1'b0, 1'b0}));
        exp_uid[0] = 4'h3; exp_uid[1] = 4'h4; exp_uid[2] = 4'h5;
        for (int i = 0; i < 3; i++) begin
            free_ack = 1'b1;
            tick();
            free_ack = 1'b0;
            chk($sformatf("fifo_drain%0d", i), 32'({done_valid, free_req, free_uid}), 32'({1'b1, 1'b1, exp_uid[i]}));
            tick();
        end
        free_ack = 1'b1;
        tick();
        free_ack = 1'b0;
        chk("fifo_empty", 32'({done_valid, free_req}), 32'({1'b1, 1'b0}));

        // Reset while holding an AR downstream.
        req_valid = 2'b10; req_id = 8'h90; alloc_gnt = 1'b1; alloc_uid = 4'hB; out_ready = 1'b0;
        tick();
        chk("rsth_alloc", 32'({req_ready, alloc_orig_id}), 32'({2'b10, 4'h9}));
        tick();
        chk("rsth_hold", 32'({out_valid, out_uid, out_src}), 32'({1'b1, 4'hB, 1'b1}));
        #2;
        rst = 1'b0;
        #1;
        chk("rsth_async", 32'({out_valid, req_ready, alloc_req}), 32'd0);
        req_valid = 2'b00; alloc_gnt = 1'b0;
        #3;
        rst = 1'b1;
        tick();
        chk("rsth_idle", 32'({out_valid, req_ready, alloc_req}), 32'd0);
`ifdef TAG_SCHED_STALL_CNT_EN
        chk("rsth_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        req_valid = 2'b10; req_id = 8'hD0; alloc_gnt = 1'b1; alloc_uid = 4'hC;
        tick();
        req_valid = 2'b00;
        chk("rsth_req1_alloc", 32'({req_ready, alloc_req, alloc_orig_id}), 32'({2'b10, 1'b1, 4'hD}));
        tick();
        out_ready = 1'b1;
        chk("rsth_req1_hold", 32'({out_valid, out_uid, out_src}), 32'({1'b1, 4'hC, 1'b1}));
        tick();
        out_ready = 1'b0; alloc_gnt = 1'b0;
        chk("rsth_req1_done", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tag_alloc_scheduler.md
TAG_ALLOC_SCHEDULER -- requirements
Module: tag_alloc_scheduler

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, original AXI ID width.
REQ-002 SHALL have parameter UID_W, default 4, allocator unique-ID width.
REQ-003 SHALL have parameter NUM_REQ, default 2, number of AR requesters (2..8).
REQ-004 SHALL have parameter FREE_DEPTH, default 4, release FIFO depth (power of 2, >=2).
REQ-005 SHALL have ports, one per line:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  asynchronous active-low reset
- req_valid  input  NUM_REQ  per-requester AR valid
- req_id  input  NUM_REQ*ID_WIDTH  per-requester original ID; requester i in bits [i*ID_WIDTH +: ID_WIDTH]
- req_ready  output  NUM_REQ  per-requester accept
- alloc_req  output  1  request to allocator
- alloc_orig_id  output  ID_WIDTH  ID presented to allocator
- alloc_gnt  input  1  same-cycle allocator grant
- alloc_uid  input  UID_W  unique ID returned with grant
- out_valid  output  1  remapped AR valid downstream
- out_uid  output  UID_W  remapped ID
- out_src  output  $clog2(NUM_REQ)  winning requester index
- out_ready  input  1  downstream accept
- rel_valid  input  1  release request (R last beat)
- rel_uid  input  UID_W  unique ID to release
- rel_ready  output  1  release FIFO not full
- free_req  output  1  free request to allocator
- free_uid  output  UID_W  unique ID being freed
- free_ack  input  1  allocator free acknowledge (arrives one cycle after free_req)
- done_valid  output  1  one-cycle pulse: free acknowledged
- done_id  input  ID_WIDTH  restored original ID from allocator, sampled with free_req

Function
REQ-006 Alloc FSM SHALL have states IDLE, ALLOC, HOLD.
REQ-007 IDLE: when any req_valid=1, SHALL latch round-robin winner (search starts at last winner+1, wraps at NUM_REQ-1) and its ID, go to ALLOC next cycle.
REQ-008 ALLOC: SHALL drive alloc_req=1, alloc_orig_id=latched ID; on alloc_gnt=1 latch alloc_uid, assert req_ready[winner] for exactly that cycle, go to HOLD; on alloc_gnt=0 stay in ALLOC (retry every cycle, no timeout).
REQ-009 HOLD: out_valid=1, out_uid/out_src stable until out_ready=1; on handshake go to IDLE.
REQ-010 Requester selected in IDLE SHALL be held even if its req_valid drops; req_ready never asserts for a non-winner.
REQ-011 Latency: minimum 2 cycles from req_valid to out_valid; one AR in flight at a time.
REQ-012 Release FIFO SHALL push on rel_valid&rel_ready; rel_ready=0 when FREE_DEPTH entries held; simultaneous push and pop when full not allowed (rel_ready deasserted).
REQ-013 Free FSM states FIDLE, FWAIT: FIDLE with FIFO non-empty drives free_req=1 for one cycle with free_uid=head, captures done_id, pops FIFO, goes FWAIT; FWAIT waits for free_ack then pulses done_valid=1, returns FIDLE.
REQ-014 Free FSM SHALL operate independently of alloc FSM; free_req and alloc_req may assert in the same cycle.
REQ-015 FIFO pointers SHALL be $clog2(FREE_DEPTH)+1 bits, wrap naturally; full/empty by MSB compare.
REQ-016 free_ack outside FWAIT SHALL be ignored.

Reset
REQ-017 rst=0 SHALL asynchronously force IDLE, FIDLE, empty FIFO, round-robin pointer to NUM_REQ-1 (first winner requester 0), all outputs 0 except rel_ready=1.
REQ-018 Reset mid-ALLOC or mid-HOLD SHALL discard the transaction; no req_ready or out_valid afterwards.

Configuration
REQ-019 Macro TAG_SCHED_STALL_CNT_EN: when defined, SHALL add output stall_cnt (16 bits), incrementing each ALLOC cycle with alloc_gnt=0, saturating at 16'hFFFF, reset to 0; when undefined, port and logic absent, behaviour otherwise identical.

Verification
REQ-020 req_valid=2'b11, IDs 3 and 5, alloc_gnt=1 always, out_ready=1 -> out_src 0 then 1, alloc_orig_id 3 then 5, out_valid 2 cycles after start.
REQ-021 ALLOC with alloc_gnt=0 for 5 cycles then 1, alloc_uid=4'hA -> alloc_req held 6 cycles, out_uid=4'hA, stall_cnt=5 when macro defined.
REQ-022 Push 4 rel_uid without free_ack -> rel_ready=0 after 4th push (3 remain after first pop); free_ack releases one per ack with done_valid pulse.
REQ-023 Simultaneous alloc_req and free_req same cycle -> both complete, no lost release or grant.
REQ-024 rst=0 while in HOLD -> out_valid=0 immediately; after release, req_valid from requester 1 only wins.
